player_choice_bank: RTL and testbench

//   Parametrised, clocked successor to the single-player choice latch. Captures the

---
 rtl/player_choice_bank.sv | 173 +++++++++++++++++
 tb/tb_player_choice_bank.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_choice_bank.sv
// Rock/Paper/Scissors choice bank for NUM_PLAYERS players: synchronised, debounced buttons,
// first-press lock-in per player, and a round FSM offering the choices over valid/ready.
module player_choice_bank #(
    parameter int NUM_PLAYERS     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_PLAYERS-1:0]     rock_btn,
    input  logic [NUM_PLAYERS-1:0]     paper_btn,
    input  logic [NUM_PLAYERS-1:0]     scissors_btn,
    input  logic                       round_start,
    input  logic                       round_clear,
    output logic [2*NUM_PLAYERS-1:0]   choices,
    output logic [NUM_PLAYERS-1:0]     locked,
    output logic                       all_locked,
    output logic                       reveal_valid,
    input  logic                       reveal_ready,
    output logic                       timed_out
);

    localparam int NBTN = 3 * NUM_PLAYERS;
    localparam int DCW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic TMO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_REVEAL  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [NBTN-1:0]           w_raw;
    logic [NBTN-1:0]           w_press;
    logic [TW-1:0]             r_timer;
    logic [2*NUM_PLAYERS-1:0]  r_choices;
    logic [NUM_PLAYERS-1:0]    r_locked;
    logic                      r_timed_out;
    logic                      w_start;
    logic                      w_timeout;
    logic                      w_tmo_hit;
    logic                      w_all_locked;

    // Button index b: rock of player p at p, paper at N+p, scissors at 2N+p.
    assign w_raw = {scissors_btn, paper_btn, rock_btn};

    for (genvar b = 0; b < NBTN; b++) begin : g_btn
        logic [1:0]     r_sync;
        logic [DCW-1:0] r_cnt;
        logic           r_stable;
        logic           r_stable_d;
        logic           r_press;

        // The press pulse is taken from the delayed stable level so capture lands
        // DEBOUNCE_CYCLES+3 edges after the raw input is first sampled high.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync     <= '0;
                r_cnt      <= '0;
                r_stable   <= 1'b0;
                r_stable_d <= 1'b0;
                r_press    <= 1'b0;
            end else begin
                r_sync     <= {r_sync[0], w_raw[b]};
                r_stable_d <= r_stable;
                r_press    <= r_stable & ~r_stable_d;
                if (r_sync[1] == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == DB_LAST) begin
                    r_cnt    <= '0;
                    r_stable <= ~r_stable;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_press[b] = r_press;
    end

    assign w_all_locked = &r_locked;
    assign w_tmo_hit    = TMO_EN && (r_timer == T_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (round_start) begin
                    w_state_nxt = ST_COLLECT;
                    w_start     = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (w_all_locked) begin
                    w_state_nxt = ST_REVEAL;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_REVEAL;
                    w_timeout   = 1'b1;
                end
            end
            ST_REVEAL: begin
                if (reveal_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Clear wins over everything, including a coincident round_start.
        if (round_clear) begin
            w_state_nxt = ST_IDLE;
            w_start     = 1'b0;
            w_timeout   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer     <= '0;
            r_choices   <= '0;
            r_locked    <= '0;
            r_timed_out <= 1'b0;
        end else if (round_clear || w_start) begin
            r_timer     <= '0;
            r_choices   <= '0;
            r_locked    <= '0;
            r_timed_out <= 1'b0;
        end else if (r_state == ST_COLLECT) begin
            if (r_timer != {TW{1'b1}}) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_timeout) begin
                r_timed_out <= 1'b1;
            end
            // Capture still runs on the timeout edge, so a last-moment press counts.
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (!r_locked[p]) begin
                    if (w_press[p]) begin
                        r_choices[2*p +: 2] <= 2'd1;
                        r_locked[p]         <= 1'b1;
                    end else if (w_press[NUM_PLAYERS + p]) begin
                        r_choices[2*p +: 2] <= 2'd2;
                        r_locked[p]         <= 1'b1;
                    end else if (w_press[2*NUM_PLAYERS + p]) begin
                        r_choices[2*p +: 2] <= 2'd3;
                        r_locked[p]         <= 1'b1;
                    end
                end
            end
        end
    end

    assign choices      = r_choices;
    assign locked       = r_locked;
    assign all_locked   = w_all_locked;
    assign reveal_valid = (r_state == ST_REVEAL);
    assign timed_out    = r_timed_out;

endmodule

// File: tb/tb_player_choice_bank.sv
// Self-checking bench for player_choice_bank: reset, hand-written round sequences,
// a table of single-round scenarios and randomized rounds against an event-level model.
module tb_player_choice_bank;

    localparam int N   = 2;
    localparam int DB  = 4;
    localparam int TMO = 20;
    localparam int NB  = 3 * N;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   rock, paper, scis;
    logic           rs, rc, rr;
    logic [2*N-1:0] choices;
    logic [N-1:0]   locked;
    logic           all_locked, reveal_valid, timed_out;

    int n_cmp = 0;
    int n_bad = 0;

    player_choice_bank #(
        .NUM_PLAYERS    (N),
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rock_btn     (rock),
        .paper_btn    (paper),
        .scissors_btn (scis),
        .round_start  (rs),
        .round_clear  (rc),
        .choices      (choices),
        .locked       (locked),
        .all_locked   (all_locked),
        .reveal_valid (reveal_valid),
        .reveal_ready (rr),
        .timed_out    (timed_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   r;
        logic [N-1:0]   p;
        logic [N-1:0]   s;
        logic [2*N-1:0] ch;
        logic [N-1:0]   lk;
        logic           to;
        int             lat;
    } vec_t;

    vec_t tbl[6];

    int unsigned o_b[NB];
    int unsigned l_b[NB];
    bit          en_b[NB];
    int          evt[NB];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_round();
        rs = 1'b1;
        tick();
        rs = 1'b0;
    endtask

    task automatic finish_reveal(input string nm);
        rr = 1'b1;
        tick();
        chk({nm, "_valid_drop"}, reveal_valid, 1'b0);
        rr = 1'b0;
        repeat (DB + 4) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rock = '0; paper = '0; scis = '0;
        rs = 1'b0; rc = 1'b0; rr = 1'b0; rst_n = 1'b0;

        tbl[0] = '{2'b01, 2'b10, 2'b00, 4'b1001, 2'b11, 1'b0, 9};
        tbl[1] = '{2'b11, 2'b11, 2'b11, 4'b0101, 2'b11, 1'b0, 9};
        tbl[2] = '{2'b00, 2'b01, 2'b11, 4'b1110, 2'b11, 1'b0, 9};
        tbl[3] = '{2'b00, 2'b00, 2'b10, 4'b1100, 2'b10, 1'b1, 20};
        tbl[4] = '{2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b1, 20};
        tbl[5] = '{2'b10, 2'b00, 2'b01, 4'b0111, 2'b11, 1'b0, 9};

        // Reset state
        #12;
        chk("rst_choices", choices, 0);
        chk("rst_locked", locked, 0);
        chk("rst_all_locked", all_locked, 0);
        chk("rst_valid", reveal_valid, 0);
        chk("rst_timed_out", timed_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_valid", reveal_valid, 0);

        // Exact capture latency, short glitch rejected, early ready, timeout
        start_round();
        rock[0] = 1'b1;
        paper[1] = 1'b1;
        repeat (3) tick();
        paper[1] = 1'b0;
        repeat (4) tick();
        chk("t1_locked_edge6", locked, 2'b00);
        tick();
        chk("t1_locked_edge7", locked, 2'b01);
        chk("t1_choice_edge7", choices, 4'b0001);
        repeat (2) tick();
        rock[0] = 1'b0;
        repeat (2) tick();
        chk("t1_glitch_locked", locked, 2'b01);
        chk("t1_glitch_choices", choices, 4'b0001);
        rr = 1'b1;
        repeat (7) tick();
        chk("t1_ready_ignored", reveal_valid, 0);
        tick();
        chk("t1_tmo_valid", reveal_valid, 1);
        chk("t1_tmo_flag", timed_out, 1);
        chk("t1_tmo_locked", locked, 2'b01);
        tick();
        chk("t1_early_ready_hs", reveal_valid, 0);
        rr = 1'b0;
        chk("t1_idle_timed_out", timed_out, 1);
        chk("t1_idle_choices", choices, 4'b0001);
        repeat (DB + 4) tick();

        // Locked choice is frozen; same-cycle priority; held reveal
        start_round();
        rock[0] = 1'b1;
        repeat (2) tick();
        scis[0] = 1'b1;
        rock[1] = 1'b1;
        paper[1] = 1'b1;
        repeat (6) tick();
        chk("t2_p0_locked", locked, 2'b01);
        chk("t2_p0_choice", choices, 4'b0001);
        repeat (2) tick();
        chk("t2_both_locked", locked, 2'b11);
        chk("t2_choices", choices, 4'b0101);
        chk("t2_valid_pre", reveal_valid, 0);
        tick();
        chk("t2_valid", reveal_valid, 1);
        rock = '0; paper = '0; scis = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t2_hold_valid_%0d", i), reveal_valid, 1);
            chk($sformatf("t2_hold_choices_%0d", i), choices, 4'b0101);
        end
        rr = 1'b1;
        tick();
        chk("t2_valid_drop", reveal_valid, 0);
        rr = 1'b0;
        chk("t2_idle_choices", choices, 4'b0101);
        chk("t2_idle_locked", locked, 2'b11);
        chk("t2_idle_timed_out", timed_out, 0);
        repeat (DB + 4) tick();

        // round_clear beats round_start in REVEAL
        start_round();
        rock = 2'b11;
        repeat (9) tick();
        chk("t5_valid", reveal_valid, 1);
        rock = '0;
        rs = 1'b1;
        rc = 1'b1;
        tick();
        rs = 1'b0;
        rc = 1'b0;
        chk("t5_valid", reveal_valid, 0);
        chk("t5_choices", choices, 0);
        chk("t5_locked", locked, 0);
        chk("t5_all_locked", all_locked, 0);
        chk("t5_timed_out", timed_out, 0);
        repeat (25) tick();
        chk("t5_no_round_valid", reveal_valid, 0);
        chk("t5_no_round_to", timed_out, 0);

        // round_clear mid-COLLECT keeps debounce state: held button gives no new press
        start_round();
        rock[0] = 1'b1;
        repeat (8) tick();
        chk("tc_locked", locked, 2'b01);
        rc = 1'b1;
        tick();
        rc = 1'b0;
        chk("tc_cleared_locked", locked, 0);
        chk("tc_cleared_choices", choices, 0);
        start_round();
        repeat (10) tick();
        chk("tc_held_no_event", locked, 0);
        rock[0] = 1'b0;
        repeat (10) tick();
        chk("tc_tmo_valid", reveal_valid, 1);
        chk("tc_tmo_flag", timed_out, 1);
        finish_reveal("tc");

        // Async reset mid-round; held button through reset; press on the timeout edge
        start_round();
        rock[0] = 1'b1;
        repeat (8) tick();
        chk("t6_locked", locked, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_locked", locked, 0);
        chk("t6_async_choices", choices, 0);
        chk("t6_async_valid", reveal_valid, 0);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) tick();
        chk("t6_idle_valid", reveal_valid, 0);
        start_round();
        repeat (6) tick();
        chk("t6_held_no_event", locked, 0);
        rock[0] = 1'b0;
        repeat (6) tick();
        rock[0] = 1'b1;
        repeat (7) tick();
        chk("t6_pre_locked", locked, 0);
        chk("t6_pre_valid", reveal_valid, 0);
        tick();
        chk("t6_edge_valid", reveal_valid, 1);
        chk("t6_edge_to", timed_out, 1);
        chk("t6_edge_locked", locked, 2'b01);
        chk("t6_edge_choices", choices, 4'b0001);
        rock[0] = 1'b0;
        finish_reveal("t6");

        // Table of single-round scenarios
        for (int v = 0; v < 6; v++) begin
            lat = -1;
            start_round();
            rock = tbl[v].r;
            paper = tbl[v].p;
            scis = tbl[v].s;
            for (int k = 1; k <= 30; k++) begin
                tick();
                if (k == 8) begin
                    rock = '0; paper = '0; scis = '0;
                end
                if (reveal_valid === 1'b1 && lat < 0) lat = k;
            end
            chk($sformatf("tbl%0d_lat", v), lat, tbl[v].lat);
            chk($sformatf("tbl%0d_valid", v), reveal_valid, 1);
            chk($sformatf("tbl%0d_choices", v), choices, tbl[v].ch);
            chk($sformatf("tbl%0d_locked", v), locked, tbl[v].lk);
            chk($sformatf("tbl%0d_all_locked", v), all_locked, &tbl[v].lk);
            chk($sformatf("tbl%0d_timed_out", v), timed_out, tbl[v].to);
            finish_reveal($sformatf("tbl%0d", v));
        end

        // Randomized rounds against an event-level model
        for (int r = 0; r < 30; r++) begin
            logic [2*N-1:0] m_ch;
            logic [N-1:0]   m_lk;
            logic           m_to;
            int             m_r;
            logic [NB-1:0]  v;
            int unsigned    dly;

            for (int b = 0; b < NB; b++) begin
                en_b[b] = ($urandom_range(0, 2) != 0);
                o_b[b]  = $urandom_range(1, 18);
                l_b[b]  = $urandom_range(1, 9);
                // A press held at least DB sampled cycles is seen DB+3 edges after it starts.
                evt[b]  = (en_b[b] && l_b[b] >= DB) ? int'(o_b[b]) + DB + 3 : -1;
            end
            m_ch = '0; m_lk = '0; m_to = 1'b0; m_r = -1;
            for (int e = 1; e <= TMO; e++) begin
                if (&m_lk) begin
                    m_r = e;
                    break;
                end
                for (int p = 0; p < N; p++) begin
                    if (!m_lk[p]) begin
                        if (evt[p] == e) begin
                            m_ch[2*p +: 2] = 2'd1; m_lk[p] = 1'b1;
                        end else if (evt[N + p] == e) begin
                            m_ch[2*p +: 2] = 2'd2; m_lk[p] = 1'b1;
                        end else if (evt[2*N + p] == e) begin
                            m_ch[2*p +: 2] = 2'd3; m_lk[p] = 1'b1;
                        end
                    end
                end
                if (e == TMO) begin
                    m_r = e;
                    m_to = 1'b1;
                end
            end

            lat = -1;
            start_round();
            for (int k = 1; k <= 45; k++) begin
                for (int b = 0; b < NB; b++) begin
                    v[b] = en_b[b] && (k >= int'(o_b[b])) && (k <= int'(o_b[b] + l_b[b]) - 1);
                end
                {scis, paper, rock} = v;
                tick();
                if (reveal_valid === 1'b1 && lat < 0) lat = k;
            end
            chk($sformatf("rnd%0d_lat", r), lat, m_r);
            chk($sformatf("rnd%0d_valid", r), reveal_valid, 1);
            chk($sformatf("rnd%0d_choices", r), choices, m_ch);
            chk($sformatf("rnd%0d_locked", r), locked, m_lk);
            chk($sformatf("rnd%0d_timed_out", r), timed_out, m_to);
            dly = $urandom_range(0, 3);
            for (int i = 0; i < int'(dly); i++) begin
                tick();
                chk($sformatf("rnd%0d_wait_valid", r), reveal_valid, 1);
            end
            finish_reveal($sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
